// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter for the IO register bus.
// Bytes written to TXDATA queue in a small FIFO and are shifted out LSB-first on tx.
module uart_tx_io #(
  parameter int                FIFO_DEPTH = 8,
  parameter int                DIV_W      = 16,
  parameter logic [DIV_W-1:0]  DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        tx,
  output logic        txIrq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovr;
  logic [DIV_W-1:0]  r_baud;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_timer;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit;

  logic [1:0]  w_sel;
  logic        w_wr;
  logic        w_rd;
  logic        w_push;
  logic        w_push_ok;
  logic        w_pop;
  logic        w_load;
  logic        w_reload;
  logic        w_shift;
  logic        w_tx;
  logic        w_empty;
  logic        w_full;
  logic        w_busy;
  logic        w_tick;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_sel     = addr[3:2];
  assign w_wr      = ce & we;
  assign w_rd      = ce & ~we;
  assign w_push    = w_wr && (w_sel == 2'b00);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_busy    = (r_state != S_IDLE);
  assign w_tick    = (r_timer == '0);
  // A full FIFO still accepts a byte when the serializer pops in the same cycle.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_status  = {24'd0, 4'(r_count), r_ovr, w_empty, w_full, w_busy};
  assign w_unused  = ^{addr[31:4], addr[1:0], wtData[31:DIV_W]};

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_reload     = 1'b0;
    w_shift      = 1'b0;
    w_tx         = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_load       = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_tick) begin
          w_reload     = 1'b1;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_tick) begin
          w_reload = 1'b1;
          w_shift  = 1'b1;
          if (r_bit == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_load       = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wtData[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovr    <= 1'b0;
      r_baud   <= DIV_RESET;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop)
        r_ovr <= 1'b1;
      else if (w_wr && (w_sel == 2'b01) && wtData[3])
        r_ovr <= 1'b0;
      if (w_wr && (w_sel == 2'b10))
        r_baud <= (wtData[DIV_W-1:0] == '0) ? DIV_W'(1) : wtData[DIV_W-1:0];
    end
  end

  // Divisor is sampled only at frame load, so BAUDDIV writes never disturb a frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= DIV_RESET;
      r_timer <= '0;
      r_shift <= 8'd0;
      r_bit   <= 3'd0;
    end else if (w_load) begin
      r_div   <= r_baud;
      r_timer <= r_baud - 1'b1;
      r_shift <= r_mem[r_rd_ptr];
      r_bit   <= 3'd0;
    end else if (w_reload) begin
      r_timer <= r_div - 1'b1;
      if (w_shift) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
    end else if (r_state != S_IDLE) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  always_comb begin
    rdData = 32'd0;
    if (w_rd) begin
      case (w_sel)
        2'b01:   rdData = w_status;
        2'b10:   rdData = 32'(r_baud);
        default: rdData = 32'd0;
      endcase
    end
  end

  assign tx    = w_tx;
  assign txIrq = w_empty & ~w_busy;

endmodule
